// File: rtl/mem_ctrl_responder.sv
// Byte-serial load/store responder between the ROB and the 8-bit RAM/IO bus.
// Optional IO write back-pressure: define MEM_CTRL_IO_STALL_EN.
module mem_ctrl_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [1:0]  IO_ADDR_HI = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  RN,
  input  logic                  WN,
  input  logic [1:0]            Width,
  input  logic                  Sign,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           Wvalue,
  output logic                  Mem_Success,
  output logic [31:0]           Read_Value,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] base;
  logic [1:0]            width_q;
  logic                  sign_q;
  logic [31:0]           wval_q;
  logic [31:0]           rbuf;
  logic [31:0]           raw_n;
  logic [2:0]            cnt;
  logic [2:0]            nxt;
  logic [2:0]            nbytes;
  logic                  last_wr;
  logic                  last_rd;
  logic                  io_region;
  logic                  stall;

  function automatic logic [31:0] extend(
    input logic [31:0] r,
    input logic [1:0]  w,
    input logic        s
  );
    logic [31:0] v;
    v = r;
    unique case (1'b1)
      (w == 2'b00): v = {{24{s & r[7]}}, r[7:0]};
      (w == 2'b01): v = {{16{s & r[15]}}, r[15:0]};
      default:      v = r;
    endcase
    return v;
  endfunction

  always_comb begin
    nbytes = 3'd4;
    unique case (1'b1)
      (width_q == 2'b00): nbytes = 3'd1;
      (width_q == 2'b01): nbytes = 3'd2;
      default:            nbytes = 3'd4;
    endcase
  end

  assign nxt       = cnt + 3'd1;
  assign last_wr   = (cnt == nbytes - 3'd1);
  assign last_rd   = (cnt == nbytes);
  assign io_region = (base[17:16] == IO_ADDR_HI);

`ifdef MEM_CTRL_IO_STALL_EN
  assign stall = io_region & io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_region & io_buffer_full;
  assign stall     = 1'b0;
`endif

  // Byte cnt-1 arrives on mem_din one cycle after its address was issued.
  always_comb begin
    raw_n = rbuf;
    unique case (cnt)
      3'd1:    raw_n[7:0]   = mem_din;
      3'd2:    raw_n[15:8]  = mem_din;
      3'd3:    raw_n[23:16] = mem_din;
      3'd4:    raw_n[31:24] = mem_din;
      default: raw_n = rbuf;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    mem_wr      = 1'b0;
    Mem_Success = 1'b0;
    unique case (state)
      IDLE: begin
        if (WN) begin
          state_n = WRITE;
        end else if (RN) begin
          state_n = READ;
        end
      end
      WRITE: begin
        mem_wr = ~stall;
        if (!stall && last_wr) begin
          state_n = DONE;
        end
      end
      READ: begin
        if (last_rd) begin
          state_n = DONE;
        end
      end
      DONE: begin
        Mem_Success = 1'b1;
        state_n     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base       <= '0;
      width_q    <= 2'b00;
      sign_q     <= 1'b0;
      wval_q     <= '0;
      rbuf       <= '0;
      cnt        <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      Read_Value <= '0;
    end else if (rdy) begin
      unique case (state)
        IDLE: begin
          if (WN || RN) begin
            base    <= Addr;
            width_q <= Width;
            sign_q  <= Sign;
            wval_q  <= Wvalue;
            rbuf    <= '0;
            cnt     <= '0;
            mem_a   <= Addr;
            if (WN) begin
              mem_dout <= Wvalue[7:0];
            end
          end
        end
        WRITE: begin
          if (!stall && !last_wr) begin
            cnt      <= nxt;
            mem_a    <= base + ADDR_WIDTH'(nxt);
            mem_dout <= wval_q[{nxt[1:0], 3'b000} +: 8];
          end
        end
        READ: begin
          cnt  <= nxt;
          rbuf <= raw_n;
          if (nxt < nbytes) begin
            mem_a <= base + ADDR_WIDTH'(nxt);
          end
          if (last_rd) begin
            Read_Value <= extend(raw_n, width_q, sign_q);
          end
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule
